uart_result_tx: RTL and testbench
=================================

// Module: uart_result_tx
// PURPOSE
//  - UART transmit side of the matrix-multiply datapath; the receive side carries operands in.
//  - Buffers result bytes from the multiplier in a small FIFO.
//  - Serialises each byte as an 8N1 frame on the TX pin (optional parity), LSB first.
//  - Sits between the multiplier result port and a uo_out pin of the top level.
// PARAMETERS
//  - CLKS_PER_BIT  87  clk cycles per UART bit (10 MHz / 115200, rounded); must be >= 2
//  - FIFO_DEPTH    4   result byte buffer depth; power of two, >= 2
// PORTS
//  - clk          in   1   system clock, rising edge
//  - rst_n        in   1   asynchronous, active-low reset
//  - ena          in   1   block enable (top-level ena)
//  - in_data      in   8   result byte from multiplier
//  - in_valid     in   1   in_data valid
//  - in_ready     out  1   FIFO can accept; = ena & ~fifo_full (no dependence on same-cycle pop)
//  - tx           out  1   UART serial out, idle high
//  - busy         out  1   frame in progress or FIFO non-empty
//  - fifo_level   out  $clog2(FIFO_DEPTH)+1   bytes currently buffered
// BEHAVIOUR
//  - Reset values: tx=1, busy=0, fifo_level=0, FSM=IDLE, FIFO pointers 0.
//    Reset asserts asynchronously; tx goes high immediately, even mid-frame, and the FIFO is flushed.
//  - Push: a byte is written on a rising edge where in_valid & in_ready; a push is ignored when full.
//  - FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> (IDLE | START).
//  - IDLE:
//    - If FIFO non-empty and ena=1: pop the head into the shift register, go to START.
//    - tx goes low on the 2nd rising edge after the accepting push edge.
//  - START: tx=0 for CLKS_PER_BIT cycles.
//  - DATA: bits 0..7, LSB first, each held CLKS_PER_BIT cycles; 3-bit bit counter.
//  - STOP: tx=1 for CLKS_PER_BIT cycles. At the last stop cycle:
//    - FIFO non-empty and ena=1: pop and go directly to START (no idle gap; frame pitch exactly 10*CLKS_PER_BIT).
//    - Otherwise: go to IDLE.
//  - Baud counter counts 0..CLKS_PER_BIT-1 and clears on every state change.
//  - Simultaneous push and pop is legal when not full; fifo_level is unchanged.
//  - Pointers wrap modulo FIFO_DEPTH; full/empty are derived from the level counter.
//  - ena=0:
//    - in_ready=0.
//    - A frame in progress completes normally.
//    - No new frame starts; buffered bytes are held until ena returns.
//  - busy = (FSM != IDLE) | (fifo_level != 0).
// CONFIGURATION
//  - Macro UART_TX_PARITY_EN.
//  - Defined:
//    - PARITY state inserted between DATA and STOP.
//    - tx = even parity (XOR of the 8 data bits), held CLKS_PER_BIT cycles.
//    - Frame pitch is 11*CLKS_PER_BIT.
//  - Undefined: PARITY state and its logic are absent; 8N1 only.
// STRUCTURE
//  - Package uart_mm_pkg:
//    - state enum (IDLE, START, DATA, PARITY, STOP)
//    - UART_DATA_W = 8
//    - constants TX_IDLE_LVL = 1'b1 and STOP_LVL = 1'b1
//  - Sub-module uart_tx_fifo: synchronous byte FIFO (push/pop/level/full/empty) with the same async reset.
//  - This module keeps the FSM, baud counter, bit counter and shift register.
// TESTING  (bench uses CLKS_PER_BIT=4, FIFO_DEPTH=4)
//  - Push 0xA5 once.
//    -> tx low 4 cycles; then 1,0,1,0,0,1,0,1 at 4 cycles each; then high 4 cycles.
//    -> busy falls after the stop bit.
//  - Hold in_valid with bytes 0x01..0x06.
//    -> 5 accepted before in_ready drops (1 in shifter + 4 buffered); 0x06 accepted after the first pop.
//    -> All six frames in order, 40-cycle pitch, tx never idle between frames.
//  - Push 0x3C, drop ena during DATA, push again.
//    -> Frame 0x3C completes; in_ready=0; no new frame until ena=1.
//  - Assert rst_n=0 mid-DATA with 3 bytes buffered.
//    -> tx=1 and fifo_level=0 immediately.
//    -> After release, no frame is sent until a new push.
//  - With UART_TX_PARITY_EN defined, push 0x07.
//    -> Parity bit = 1, stop follows, 44-cycle frame.
//    -> Push 0x03 -> parity bit = 0.
//  - Push at a STOP->START pop edge with FIFO full.
//    -> Push refused (in_ready=0 that cycle); fifo_level goes 4 -> 3 with no byte lost or duplicated.

Source files
------------

// File: rtl/uart_mm_pkg.sv
// Shared types and constants for the matrix-multiply UART blocks.
package uart_mm_pkg;

  localparam int UART_DATA_W = 8;

  localparam logic TX_IDLE_LVL = 1'b1;
  localparam logic STOP_LVL    = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  function automatic logic even_parity(input logic [UART_DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_result_tx_if.sv
// Valid/ready byte handshake from the multiplier result port into the UART transmitter.
interface uart_result_tx_if;
  import uart_mm_pkg::*;

  logic [UART_DATA_W-1:0] in_data;
  logic                   in_valid;
  logic                   in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO; full/empty come from the level counter, pointers wrap modulo DEPTH.
module uart_tx_fifo
  import uart_mm_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [UART_DATA_W-1:0] wdata,
  output logic [UART_DATA_W-1:0] rdata,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [UART_DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic                   do_push;
  logic                   do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_result_tx.sv
// Buffered UART transmitter for multiplier result bytes, 8N1 LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_result_tx
  import uart_mm_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ena,
  uart_result_tx_if.slave             in_bus,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  tx_state_e              state;
  tx_state_e              state_next;
  logic [CW-1:0]          baud;
  logic [2:0]             bit_cnt;
  logic [UART_DATA_W-1:0] shifter;
  logic [UART_DATA_W-1:0] head;
  logic                   bit_end;
  logic                   can_pop;
  logic                   pop;
  logic                   ready;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   tx_next;
`ifdef UART_TX_PARITY_EN
  logic                   parity_bit;
`endif

  assign bit_end         = (baud == CW'(CLKS_PER_BIT - 1));
  assign can_pop         = ena & ~fifo_empty;
  assign ready           = ena & ~fifo_full;
  assign in_bus.in_ready = ready;
  assign busy            = (state != IDLE) | (fifo_level != '0);

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_bus.in_valid & ready),
    .pop   (pop),
    .wdata (in_bus.in_data),
    .rdata (head),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:   if (can_pop) state_next = START;
      START:  if (bit_end) state_next = DATA;
`ifdef UART_TX_PARITY_EN
      DATA:   if (bit_end && bit_cnt == 3'd7) state_next = PARITY;
      PARITY: if (bit_end) state_next = STOP;
`else
      DATA:   if (bit_end && bit_cnt == 3'd7) state_next = STOP;
`endif
      STOP:   if (bit_end) state_next = can_pop ? START : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // tx_next is registered, so the pin lags the state by one clock for every bit alike.
  always_comb begin
    pop     = 1'b0;
    tx_next = TX_IDLE_LVL;
    case (state)
      IDLE:   pop = can_pop;
      START:  tx_next = 1'b0;
      DATA:   tx_next = shifter[0];
`ifdef UART_TX_PARITY_EN
      PARITY: tx_next = parity_bit;
`endif
      STOP: begin
        tx_next = STOP_LVL;
        pop     = can_pop & bit_end;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx      <= TX_IDLE_LVL;
      baud    <= '0;
      bit_cnt <= '0;
      shifter <= '0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      tx <= tx_next;
      if (state == IDLE || state_next != state || bit_end) baud <= '0;
      else                                                 baud <= baud + CW'(1);
      if (pop) begin
        shifter <= head;
        bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
        parity_bit <= even_parity(head);
`endif
      end else if (state == DATA && bit_end) begin
        shifter <= shifter >> 1;
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_result_tx.sv
// Directed-plus-random bench for uart_result_tx with a serial-line receiver model and byte scoreboard.
module tb_uart_result_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR_EN     = 1'b1;
  localparam int FRAME_BITS = 11;
`else
  localparam bit PAR_EN     = 1'b0;
  localparam int FRAME_BITS = 10;
`endif
  localparam int PITCH = FRAME_BITS * CPB;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_level;

  uart_result_tx_if bus ();

  uart_result_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .in_bus     (bus),
    .tx         (tx),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int         rx_start_q[$];
  bit         rx_ok_q[$];
  bit         rx_par_q[$];
  logic       last_ready;

  // Line receiver: samples mid-bit, records byte, start cycle, framing and parity.
  bit         mon_active;
  int         mon_start;
  logic [7:0] mon_byte;
  bit         mon_ok;
  bit         mon_par;
  always @(negedge clk) begin
    int off;
    int j;
    if (!rst_n) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (tx == 1'b0) begin
        mon_active = 1'b1;
        mon_start  = cyc;
        mon_ok     = 1'b1;
        mon_byte   = 8'h00;
        mon_par    = 1'b0;
      end
    end else begin
      off = cyc - mon_start;
      if (off % CPB == 2) begin
        j = off / CPB;
        if (j == 0) mon_ok = mon_ok & (tx === 1'b0);
        else if (j <= 8) mon_byte[j-1] = tx;
        else if (PAR_EN && j == 9) mon_par = tx;
        else if (j == FRAME_BITS - 1) begin
          mon_ok = mon_ok & (tx === 1'b1);
          rx_q.push_back(mon_byte);
          rx_start_q.push_back(mon_start);
          rx_ok_q.push_back(mon_ok);
          rx_par_q.push_back(mon_par);
          mon_active = 1'b0;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: record an accepted byte just before the edge, return at the next falling edge.
  task automatic step();
    #4;
    last_ready = bus.in_ready;
    if (rst_n && bus.in_valid && bus.in_ready) exp_q.push_back(bus.in_data);
    @(negedge clk);
  endtask

  // Expected line level k cycles after the edge that accepted byte b into an idle block.
  function automatic logic exp_tx(input logic [7:0] b, input int k);
    int idx;
    if (k < 2) return 1'b1;
    idx = (k - 2) / CPB;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (PAR_EN && idx == 9) return ^b;
    return 1'b1;
  endfunction

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while ((busy !== 1'b0 || mon_active) && n < budget) begin
      step();
      n++;
    end
    chk({tag, " drain"}, 32'(n < budget), 32'd1);
    repeat (4) step();
  endtask

  task automatic clear_q();
    exp_q.delete();
    rx_q.delete();
    rx_start_q.delete();
    rx_ok_q.delete();
    rx_par_q.delete();
  endtask

  task automatic sb(input string tag, input bit check_pitch);
    chk({tag, " count"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      chk($sformatf("%s byte%0d", tag, i), rx_q[i], exp_q[i]);
      chk($sformatf("%s frame%0d", tag, i), rx_ok_q[i], 1);
      if (PAR_EN) chk($sformatf("%s par%0d", tag, i), rx_par_q[i], ^exp_q[i]);
      if (check_pitch && i > 0)
        chk($sformatf("%s pitch%0d", tag, i), rx_start_q[i] - rx_start_q[i-1], PITCH);
    end
    clear_q();
  endtask

  initial begin
    int n;
    int drop_acc;
    int drop_lvl;
    int zeros;
    bit found;
    int prev;
    logic [7:0] b;

    rst_n        = 1'b0;
    ena          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    @(negedge clk);
    @(negedge clk);
    chk("reset tx", tx, 1);
    chk("reset busy", busy, 0);
    chk("reset level", fifo_level, 0);
    chk("reset ready", bus.in_ready, 1);
    rst_n = 1'b1;
    repeat (2) step();

    // Single frame, cycle-exact waveform.
    bus.in_data  = 8'hA5;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    for (int k = 1; k <= PITCH + 2; k++) begin
      step();
      chk($sformatf("A5 tx k=%0d", k), tx, exp_tx(8'hA5, k));
      if (k == PITCH)     chk("A5 busy before end", busy, 1);
      if (k == PITCH + 1) chk("A5 busy after stop", busy, 0);
    end
    drain("A5", 200);
    sb("A5", 1'b0);

    // Held valid with 0x01..0x06: back-pressure and back-to-back frames.
    bus.in_data  = 8'h01;
    bus.in_valid = 1'b1;
    drop_acc     = -1;
    drop_lvl     = -1;
    n            = 0;
    while (exp_q.size() < 6 && n < 400) begin
      step();
      n++;
      bus.in_data = 8'(exp_q.size() + 1);
      if (exp_q.size() >= 6) bus.in_valid = 1'b0;
      if (bus.in_ready === 1'b0 && drop_acc < 0) begin
        drop_acc = exp_q.size();
        drop_lvl = int'(fifo_level);
      end
    end
    bus.in_valid = 1'b0;
    chk("burst accepted before drop", drop_acc, 5);
    chk("burst level at drop", drop_lvl, DEPTH);
    chk("burst total accepted", exp_q.size(), 6);
    drain("burst", 1000);
    sb("burst", 1'b1);

    // ena dropped mid-frame: current frame finishes, buffered byte is held.
    bus.in_data  = 8'h3C;
    bus.in_valid = 1'b1;
    step();
    bus.in_data = 8'h5A;
    step();
    bus.in_valid = 1'b0;
    repeat (12) step();
    ena = 1'b0;
    #1;
    chk("ena0 ready", bus.in_ready, 0);
    bus.in_data  = 8'h77;
    bus.in_valid = 1'b1;
    repeat (60) step();
    chk("ena0 frames", rx_q.size(), 1);
    chk("ena0 first byte", (rx_q.size() > 0) ? rx_q[0] : 8'hxx, 8'h3C);
    chk("ena0 held level", fifo_level, 1);
    chk("ena0 busy", busy, 1);
    chk("ena0 tx idle", tx, 1);
    chk("ena0 no accept", exp_q.size(), 2);
    ena = 1'b1;
    n   = 0;
    while (exp_q.size() < 3 && n < 200) begin
      step();
      n++;
    end
    bus.in_valid = 1'b0;
    chk("ena1 accept", exp_q.size(), 3);
    drain("ena", 1000);
    sb("ena", 1'b0);

    // Asynchronous reset mid-DATA with three bytes buffered.
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      bus.in_data = 8'($urandom);
      step();
    end
    bus.in_valid = 1'b0;
    repeat (10) step();
    chk("prereset tx low", tx, 0);
    chk("prereset level", fifo_level, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset tx", tx, 1);
    chk("async reset level", fifo_level, 0);
    chk("async reset busy", busy, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clear_q();
    zeros = 0;
    for (int i = 0; i < 80; i++) begin
      step();
      if (tx !== 1'b1) zeros++;
    end
    chk("post reset quiet", zeros, 0);
    chk("post reset frames", rx_q.size(), 0);
    bus.in_data  = 8'($urandom);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    drain("post reset", 200);
    sb("post reset", 1'b0);

    // Push attempted on the STOP->START pop edge while full.
    bus.in_data  = 8'($urandom);
    bus.in_valid = 1'b1;
    n = 0;
    while (!(fifo_level == 3'(DEPTH) && bus.in_ready === 1'b0) && n < 30) begin
      prev = exp_q.size();
      step();
      n++;
      if (exp_q.size() != prev) bus.in_data = 8'($urandom);
    end
    chk("full reached", fifo_level, DEPTH);
    found = 1'b0;
    n = 0;
    while (!found && n < 80) begin
      prev = int'(fifo_level);
      step();
      n++;
      if (prev == DEPTH && fifo_level == 3'(DEPTH - 1)) found = 1'b1;
    end
    chk("full pop seen", found, 1);
    chk("full pop ready", last_ready, 0);
    prev = exp_q.size();
    step();
    chk("refill level", fifo_level, DEPTH);
    chk("refill accepted", exp_q.size(), prev + 1);
    bus.in_valid = 1'b0;
    drain("full", 1000);
    sb("full", 1'b1);

    if (PAR_EN) begin
      bus.in_data  = 8'h07;
      bus.in_valid = 1'b1;
      step();
      bus.in_data = 8'h03;
      step();
      bus.in_valid = 1'b0;
      drain("parity", 400);
      chk("parity 07", (rx_par_q.size() > 0) ? 32'(rx_par_q[0]) : 32'hx, 1);
      chk("parity 03", (rx_par_q.size() > 1) ? 32'(rx_par_q[1]) : 32'hx, 0);
      sb("parity", 1'b1);
    end

    // Random traffic with occasional ena pauses.
    for (int i = 0; i < 600; i++) begin
      bus.in_valid = ($urandom_range(0, 3) != 0);
      b            = 8'($urandom);
      bus.in_data  = b;
      if ($urandom_range(0, 49) == 0) ena = ~ena;
      step();
    end
    bus.in_valid = 1'b0;
    ena          = 1'b1;
    drain("random", 3000);
    sb("random", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
